// File: rtl/clk_div_ctrl.sv
// Clock-divider reconfiguration controller: accepts a new divide ratio, lets the
// running divided period finish, gates and clears the divider, then re-enables it.
module clk_div_ctrl #(
    parameter int DIV_WIDTH     = 8,
    parameter int DEFAULT_DIV   = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_req_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 div_en_o,
    output logic                 div_clr_o,
    output logic [DIV_WIDTH-1:0] div_ratio_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [DIV_WIDTH-1:0] RESET_RATIO = DIV_WIDTH'(DEFAULT_DIV);

    typedef enum logic [2:0] {IDLE, DRAIN, GATE, CLEAR, SETTLE} state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] ratio_q, ratio_d;
    logic [DIV_WIDTH-1:0] pendRatio_q, pendRatio_d;
    logic [DIV_WIDTH-1:0] drainCnt_q, drainCnt_d;
    logic [SW-1:0]        settleCnt_q, settleCnt_d;
    logic                 enReq_q;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 xfer;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ratio_q     <= RESET_RATIO;
            pendRatio_q <= RESET_RATIO;
            drainCnt_q  <= '0;
            settleCnt_q <= '0;
            enReq_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ratio_q     <= ratio_d;
            pendRatio_q <= pendRatio_d;
            drainCnt_q  <= drainCnt_d;
            settleCnt_q <= settleCnt_d;
            enReq_q     <= en_req_i;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign xfer = div_valid_i && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        ratio_d     = ratio_q;
        pendRatio_d = pendRatio_q;
        drainCnt_d  = drainCnt_q;
        settleCnt_d = settleCnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (div_i == '0) begin
                        err_d = 1'b1;
                    end else if (div_i == ratio_q) begin
                        done_d = 1'b1;
                    end else begin
                        pendRatio_d = div_i;
                        // Let the divided period in flight finish before gating.
                        if (div_en_o) begin
                            state_d    = DRAIN;
                            drainCnt_d = ratio_q - DIV_WIDTH'(1);
                        end else begin
                            state_d = GATE;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drainCnt_q == '0) state_d = GATE;
                else                  drainCnt_d = drainCnt_q - DIV_WIDTH'(1);
            end
            GATE: begin
                state_d = CLEAR;
                ratio_d = pendRatio_q;
            end
            CLEAR: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d     = SETTLE;
                    settleCnt_d = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (settleCnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    settleCnt_d = settleCnt_q - SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign div_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign div_en_o    = (state_q == IDLE) ? enReq_q : (state_q == DRAIN);
    assign div_clr_o   = (state_q == CLEAR);
    assign div_ratio_o = ratio_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with default parameters
// (ratio 4 out of reset, two settle cycles).
module tb_clk_div_ctrl;

    logic       clk;
    logic       rst;
    logic       enReq;
    logic [7:0] divIn;
    logic       divValid;
    logic       divReady;
    logic       divEn;
    logic       divClr;
    logic [7:0] divRatio;
    logic       busy;
    logic       done;
    logic       err;

    int passCount = 0;
    int checkCount = 0;

    clk_div_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_req_i    (enReq),
        .div_i       (divIn),
        .div_valid_i (divValid),
        .div_ready_o (divReady),
        .div_en_o    (divEn),
        .div_clr_o   (divClr),
        .div_ratio_o (divRatio),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] d);
        enReq    = en;
        divValid = valid;
        divIn    = d;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " ratio"}, divRatio, 8'd4);
        checkOutput({tag, " ready"}, 8'(divReady), 8'd1);
        checkOutput({tag, " en"},    8'(divEn),    8'd0);
        checkOutput({tag, " clr"},   8'(divClr),   8'd0);
        checkOutput({tag, " busy"},  8'(busy),     8'd0);
        checkOutput({tag, " done"},  8'(done),     8'd0);
        checkOutput({tag, " err"},   8'(err),      8'd0);
    endtask

    // Bit c of each table is the expected value during cycle c of a scenario,
    // cycle 0 being the cycle in which the transfer is presented.
    logic [9:0]  expEnA   = 10'b1000011111;
    logic [9:0]  expClrA  = 10'b0001000000;
    logic [9:0]  expBusyA = 10'b0111111110;
    logic [9:0]  expDoneA = 10'b1000000000;
    logic [5:0]  expClrB  = 6'b000100;
    logic [5:0]  expBusyB = 6'b011110;
    logic [5:0]  expDoneB = 6'b100000;
    logic [11:0] expClrE  = 12'b000010000100;
    logic [11:0] expBusyE = 12'b001111011110;
    logic [11:0] expDoneE = 12'b010000100000;

    int sawDone;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0);
        #12;
        checkResetOutputs("reset");
        step();
        rst = 1'b0;
        step();

        // Illegal ratio 0, then a request for the ratio already applied.
        applyStimulus(1'b0, 1'b1, 8'd0);
        step();
        checkOutput("zero err",   8'(err),  8'd1);
        checkOutput("zero done",  8'(done), 8'd0);
        checkOutput("zero ratio", divRatio, 8'd4);
        checkOutput("zero busy",  8'(busy), 8'd0);
        applyStimulus(1'b0, 1'b1, 8'd4);
        step();
        checkOutput("same done",  8'(done), 8'd1);
        checkOutput("same err",   8'(err),  8'd0);
        checkOutput("same busy",  8'(busy), 8'd0);
        applyStimulus(1'b0, 1'b0, 8'd0);
        step();
        checkOutput("same done clears", 8'(done), 8'd0);

        // Enabled divider: drain 4 cycles, gate, clear, settle, resume.
        applyStimulus(1'b1, 1'b0, 8'd0);
        step();
        step();
        applyStimulus(1'b1, 1'b1, 8'd6);
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("A%0d en", c),    8'(divEn),  8'(expEnA[c]));
            checkOutput($sformatf("A%0d clr", c),   8'(divClr), 8'(expClrA[c]));
            checkOutput($sformatf("A%0d busy", c),  8'(busy),   8'(expBusyA[c]));
            checkOutput($sformatf("A%0d ready", c), 8'(divReady), 8'(!expBusyA[c]));
            checkOutput($sformatf("A%0d done", c),  8'(done),   8'(expDoneA[c]));
            checkOutput($sformatf("A%0d ratio", c), divRatio, (c >= 6) ? 8'd6 : 8'd4);
            step();
            if (c == 0) applyStimulus(1'b1, 1'b0, 8'd0);
        end
        checkOutput("A done clears", 8'(done), 8'd0);

        // Disabled divider: no drain, divider enable stays low throughout.
        applyStimulus(1'b0, 1'b0, 8'd0);
        step();
        step();
        step();
        applyStimulus(1'b0, 1'b1, 8'd3);
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("B%0d en", c),    8'(divEn),  8'd0);
            checkOutput($sformatf("B%0d clr", c),   8'(divClr), 8'(expClrB[c]));
            checkOutput($sformatf("B%0d busy", c),  8'(busy),   8'(expBusyB[c]));
            checkOutput($sformatf("B%0d done", c),  8'(done),   8'(expDoneB[c]));
            checkOutput($sformatf("B%0d ratio", c), divRatio, (c >= 2) ? 8'd3 : 8'd6);
            step();
            if (c == 0) applyStimulus(1'b0, 1'b0, 8'd0);
        end

        // Reset in the middle of a drain discards the request.
        applyStimulus(1'b1, 1'b0, 8'd0);
        step();
        step();
        applyStimulus(1'b1, 1'b1, 8'd8);
        step();
        applyStimulus(1'b1, 1'b0, 8'd0);
        step();
        checkOutput("D drain busy", 8'(busy), 8'd1);
        checkOutput("D drain en",   8'(divEn), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("D async reset");
        step();
        rst = 1'b0;
        sawDone = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (done) sawDone++;
        end
        checkOutput("D no done after reset", 8'(sawDone), 8'd0);
        checkOutput("D ratio after reset", divRatio, 8'd4);
        checkOutput("D en tracks request", 8'(divEn), 8'd1);

        // Valid held through a busy period: second request waits for IDLE.
        applyStimulus(1'b0, 1'b0, 8'd0);
        step();
        step();
        applyStimulus(1'b0, 1'b1, 8'd5);
        for (int c = 0; c < 12; c++) begin
            checkOutput($sformatf("E%0d clr", c),   8'(divClr), 8'(expClrE[c]));
            checkOutput($sformatf("E%0d busy", c),  8'(busy),   8'(expBusyE[c]));
            checkOutput($sformatf("E%0d ready", c), 8'(divReady), 8'(!expBusyE[c]));
            checkOutput($sformatf("E%0d done", c),  8'(done),   8'(expDoneE[c]));
            checkOutput($sformatf("E%0d err", c),   8'(err),    8'd0);
            checkOutput($sformatf("E%0d ratio", c), divRatio,
                        (c >= 7) ? 8'd7 : ((c >= 2) ? 8'd5 : 8'd4));
            step();
            if (c == 0) applyStimulus(1'b0, 1'b1, 8'd7);
            if (c == 5) applyStimulus(1'b0, 1'b0, 8'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_WIDTH, default 8: width of the divide-ratio field.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 4: divide ratio applied out of reset (1..2^DIV_WIDTH-1).
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 2: cycles of held-off enable after a ratio change (0 allowed).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en_req_i, input, 1 bit: requested divider enable.
REQ-007 The block SHALL have port div_i, input, DIV_WIDTH bits: new divide ratio.
REQ-008 The block SHALL have port div_valid_i, input, 1 bit: div_i valid.
REQ-009 The block SHALL have port div_ready_o, output, 1 bit: controller can accept a ratio.
REQ-010 The block SHALL have port div_en_o, output, 1 bit: enable to the divider.
REQ-011 The block SHALL have port div_clr_o, output, 1 bit: synchronous clear to the divider.
REQ-012 The block SHALL have port div_ratio_o, output, DIV_WIDTH bits: ratio currently applied to the divider.
REQ-013 The block SHALL have port busy_o, output, 1 bit: a reconfiguration is in progress.
REQ-014 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when a request completes.
REQ-015 The block SHALL have port err_o, output, 1 bit: one-cycle pulse when an illegal ratio is rejected.

Function
REQ-016 The FSM SHALL have states IDLE, DRAIN, GATE, CLEAR and SETTLE; all outputs SHALL be registered or decoded from state only.
REQ-017 div_ready_o SHALL be 1 exactly in IDLE; a transfer occurs on a cycle with div_valid_i & div_ready_o.
REQ-018 In IDLE, div_en_o SHALL equal en_req_i delayed by one cycle.
REQ-019 A transfer with div_i==0 SHALL be consumed, pulse err_o on the next cycle, stay in IDLE and leave div_ratio_o unchanged.
REQ-020 A transfer with div_i==div_ratio_o SHALL be consumed, pulse done_o on the next cycle and stay in IDLE, with no gating.
REQ-021 On any other transfer, the new ratio SHALL be captured, busy_o SHALL be 1 from the next cycle until the return to IDLE, and en_req_i SHALL be ignored while busy.
REQ-022 If div_en_o==1 in the transfer cycle, the next state SHALL be DRAIN; otherwise it SHALL be GATE.
REQ-023 DRAIN SHALL hold div_en_o=1 for exactly div_ratio_o cycles via a down-counter, so the current divided period completes, then go to GATE.
REQ-024 GATE SHALL last 1 cycle with div_en_o=0.
REQ-025 CLEAR SHALL last 1 cycle with div_clr_o=1 and div_en_o=0; div_ratio_o SHALL show the new ratio from the first CLEAR cycle.
REQ-026 SETTLE SHALL last SETTLE_CYCLES cycles with div_en_o=0; when SETTLE_CYCLES==0 the FSM SHALL go from CLEAR directly to IDLE.
REQ-027 done_o SHALL pulse in the first IDLE cycle after SETTLE (or after CLEAR), and div_en_o SHALL resume tracking en_req_i from that cycle.
REQ-028 div_clr_o SHALL be 1 only in CLEAR.
REQ-029 done_o and err_o SHALL never be 1 in the same cycle.
REQ-030 The DRAIN counter SHALL be DIV_WIDTH bits wide and SHALL not wrap: it loads div_ratio_o-1 and exits at 0.

Reset
REQ-031 rst_i SHALL act asynchronously in any state, including mid-reconfiguration, and SHALL force: state IDLE, div_ratio_o=DEFAULT_DIV, div_en_o=0, div_clr_o=0, busy_o=0, done_o=0, err_o=0, div_ready_o=1, DRAIN counter 0.
REQ-032 A request interrupted by reset SHALL be discarded; no done_o SHALL follow it.

Verification
REQ-033 Scenario: reset released, en_req_i=1, transfer div_i=6 at cycle 0 -> DRAIN cycles 1-4, GATE at cycle 5, CLEAR at cycle 6 (div_ratio_o=6, div_clr_o=1), SETTLE cycles 7-8, done_o and div_en_o=1 at cycle 9.
REQ-034 Scenario: en_req_i=0 for 2+ cycles, transfer div_i=3 -> no DRAIN; GATE at cycle 1, CLEAR at cycle 2, done_o at cycle 5; div_en_o stays 0.
REQ-035 Scenario: transfer div_i=0 -> err_o pulse next cycle, div_ratio_o stays 4; transfer div_i=4 -> done_o next cycle, busy_o stays 0.
REQ-036 Scenario: rst_i asserted during DRAIN of a div_i=8 request -> outputs immediately at reset values, div_ratio_o=4, no done_o after release.
REQ-037 Scenario: div_valid_i held high during busy -> div_ready_o=0 and no second transfer until IDLE; back-to-back requests are each fully sequenced.
